// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI memory transaction controller:
// state encoding, default frame geometry and the per-state output decode.
package spi_pkg;

    localparam int SPI_WIDTH  = 8;
    localparam int SPI_SETTLE = 2;

    typedef enum logic [3:0] {
        IDLE         = 4'd0,
        GET          = 4'd1,
        GOT          = 4'd2,
        ADDR         = 4'd3,
        READ_LOAD    = 4'd4,
        READ_SHIFT   = 4'd5,
        WRITE_GET    = 4'd6,
        WRITE_SETTLE = 4'd7,
        WRITE_COMMIT = 4'd8,
        DONE         = 4'd9
    } state_t;

    typedef struct packed {
        logic sr_we;
        logic addr_we;
        logic dm_we;
        logic miso_bufe;
    } fsm_out_t;

    // Outputs are a pure function of the state being entered.
    function automatic fsm_out_t decode_outputs(input state_t state);
        fsm_out_t o;
        o           = '0;
        o.sr_we     = (state == READ_LOAD);
        o.addr_we   = (state == ADDR);
        o.dm_we     = (state == WRITE_COMMIT);
        o.miso_bufe = (state == READ_SHIFT);
        return o;
    endfunction

endpackage

// File: rtl/spi_edge_counter.sv
// Strobe counter with clear and enable; done_o flags the enabled strobe that
// brings the count to LIMIT. Used both for sclk bits and for clk settle waits.
module spi_edge_counter #(
    parameter int LIMIT = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic en_i,
    output logic done_o
);

    localparam int           W    = $clog2(LIMIT) + 1;
    localparam logic [W-1:0] LAST = W'(LIMIT - 1);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        // NOTE: default first so every path assigns count_d and no latch is inferred.
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking so every register samples pre-edge values.
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done_o = en_i && (count_q == LAST);

endmodule

// File: rtl/spi_fsm.sv
// SPI memory transaction controller: address/RW byte, then read or write byte.
// Define SPI_FSM_TXN_COUNT_EN to add the txnCount completed-frame counter.
module spi_fsm
    import spi_pkg::*;
#(
    parameter int width  = SPI_WIDTH,
    parameter int settle = SPI_SETTLE
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       csConditioned,
    input  logic       sclkPosEdge,
    input  logic       sclkNegEdge,
    input  logic       rwBit,
    output logic       srWe,
    output logic       addrWe,
    output logic       dmWe,
    output logic       misoBufe
`ifdef SPI_FSM_TXN_COUNT_EN
    ,
    output logic [7:0] txnCount
`endif
);

    state_t   state_q;
    state_t   state_d;
    fsm_out_t out_q;
    fsm_out_t out_d;

    logic bit_en;
    logic bit_clr;
    logic bit_done;
    logic settle_en;
    logic settle_clr;
    logic settle_done;

    // Each counting state listens to one sclk edge type only.
    assign bit_en = ((state_q == GET || state_q == WRITE_GET) && sclkPosEdge) ||
                    ((state_q == READ_SHIFT) && sclkNegEdge);
    assign settle_en = (state_q == GOT) || (state_q == WRITE_SETTLE);

    // Any state change (including abort) restarts both counters from zero.
    assign bit_clr    = (state_d != state_q);
    assign settle_clr = (state_d != state_q);

    spi_edge_counter #(
        .LIMIT (width)
    ) u_bit_counter (
        .clk    (clk),
        .reset  (reset),
        .clr_i  (bit_clr),
        .en_i   (bit_en),
        .done_o (bit_done)
    );

    spi_edge_counter #(
        .LIMIT (settle)
    ) u_settle_counter (
        .clk    (clk),
        .reset  (reset),
        .clr_i  (settle_clr),
        .en_i   (settle_en),
        .done_o (settle_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (state_q != IDLE && csConditioned) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:         if (!csConditioned) state_d = GET;
                GET:          if (bit_done)       state_d = GOT;
                GOT:          if (settle_done)    state_d = ADDR;
                ADDR:         state_d = rwBit ? READ_LOAD : WRITE_GET;
                READ_LOAD:    state_d = READ_SHIFT;
                READ_SHIFT:   if (bit_done)       state_d = DONE;
                WRITE_GET:    if (bit_done)       state_d = WRITE_SETTLE;
                WRITE_SETTLE: if (settle_done)    state_d = WRITE_COMMIT;
                WRITE_COMMIT: state_d = DONE;
                DONE:         state_d = DONE;
                default:      state_d = IDLE;
            endcase
        end
    end

    // Decoding the next state keeps the registered outputs aligned with the state.
    always_comb begin
        out_d = decode_outputs(state_d);
    end

    assign srWe     = out_q.sr_we;
    assign addrWe   = out_q.addr_we;
    assign dmWe     = out_q.dm_we;
    assign misoBufe = out_q.miso_bufe;

`ifdef SPI_FSM_TXN_COUNT_EN
    logic [7:0] txn_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            txn_q <= '0;
        end else if (state_d == DONE && state_q != DONE) begin
            txn_q <= txn_q + 8'd1;
        end
    end

    assign txnCount = txn_q;
`endif

endmodule

// File: tb/tb_spi_fsm.sv
// Self-checking bench for spi_fsm: frame-level timing model feeds a scoreboard
// of expected output pulses; a negedge monitor compares DUT events against it.
module tb_spi_fsm;
    import spi_pkg::*;

    localparam int S = SPI_SETTLE;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic csConditioned = 1'b0;
    logic sclkPosEdge = 1'b0;
    logic sclkNegEdge = 1'b0;
    logic rwBit = 1'b0;
    logic srWe, addrWe, dmWe, misoBufe;
`ifdef SPI_FSM_TXN_COUNT_EN
    logic [7:0] txnCount;
`endif

    spi_fsm #(
        .width  (SPI_WIDTH),
        .settle (SPI_SETTLE)
    ) dut (
`ifdef SPI_FSM_TXN_COUNT_EN
        .txnCount      (txnCount),
`endif
        .clk           (clk),
        .reset         (reset),
        .csConditioned (csConditioned),
        .sclkPosEdge   (sclkPosEdge),
        .sclkNegEdge   (sclkNegEdge),
        .rwBit         (rwBit),
        .srWe          (srWe),
        .addrWe        (addrWe),
        .dmWe          (dmWe),
        .misoBufe      (misoBufe)
    );

    always #5 clk = ~clk;

    typedef enum int {EV_ADDR, EV_SR, EV_DM, EV_MISO_RISE, EV_MISO_FALL} ev_kind_t;
    typedef struct {
        ev_kind_t kind;
        int       cyc;
    } ev_t;

    ev_t      exp_q[$];
    ev_kind_t seen_q[$];
    ev_t      head;
    ev_kind_t cur_kind;
    bit       prev_miso = 1'b0;
    int       cyc = 0;
    int       n_checks = 0;
    int       n_pass = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Scoreboard monitor: every observed pulse/edge pops one expectation.
    initial forever begin
        @(negedge clk);
        seen_q.delete();
        if (addrWe === 1'b1) seen_q.push_back(EV_ADDR);
        if (srWe === 1'b1) seen_q.push_back(EV_SR);
        if (dmWe === 1'b1) seen_q.push_back(EV_DM);
        if (misoBufe === 1'b1 && !prev_miso) seen_q.push_back(EV_MISO_RISE);
        if (misoBufe !== 1'b1 && prev_miso) seen_q.push_back(EV_MISO_FALL);
        prev_miso = (misoBufe === 1'b1);
        foreach (seen_q[i]) begin
            cur_kind = seen_q[i];
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL scoreboard: got %s at cycle %0d, expected no event",
                         cur_kind.name(), cyc);
            end else begin
                head = exp_q.pop_front();
                if (head.kind !== cur_kind || head.cyc !== cyc) begin
                    $display("FAIL scoreboard: got %s at cycle %0d, expected %s at cycle %0d",
                             cur_kind.name(), cyc, head.kind.name(), head.cyc);
                end else begin
                    n_pass++;
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sclk_strobe(input bit pos);
        if (pos) sclkPosEdge = 1'b1;
        else     sclkNegEdge = 1'b1;
        tick();
        sclkPosEdge = 1'b0;
        sclkNegEdge = 1'b0;
        tick();
    endtask

    // Drives a frame with a 4-clk sclk period and pushes expected events.
    task automatic run_frame(input logic [6:0] addr, input bit is_read,
                             input logic [7:0] data, input int n_periods,
                             input int abort_after, output bit completed);
        logic [15:0] frame;
        int addr_edges = 0;
        int data_pos = 0;
        int data_neg = 0;
        int k = -1;
        int total_pos = 0;
        int c;
        completed = 1'b0;
        frame = {addr, is_read, data};
        csConditioned = 1'b0;
        tick();
        for (int p = 0; p < n_periods; p++) begin
            c = cyc;
            total_pos++;
            if (addr_edges < 8) begin
                rwBit = frame[15 - addr_edges];
                addr_edges++;
                if (addr_edges == 8) begin
                    k = c;
                    exp_q.push_back('{kind: EV_ADDR, cyc: k + S + 1});
                    if (is_read) begin
                        exp_q.push_back('{kind: EV_SR, cyc: k + S + 2});
                        exp_q.push_back('{kind: EV_MISO_RISE, cyc: k + S + 3});
                    end
                end
            end else if (!is_read && data_pos < 8 && c >= k + S + 2) begin
                rwBit = frame[7 - data_pos];
                data_pos++;
                if (data_pos == 8) exp_q.push_back('{kind: EV_DM, cyc: c + S + 1});
            end
            sclk_strobe(1'b1);
            if (abort_after != 0 && total_pos == abort_after) begin
                csConditioned = 1'b1;
                return;
            end
            c = cyc;
            if (is_read && k >= 0 && data_neg < 8 && c >= k + S + 3) begin
                data_neg++;
                if (data_neg == 8) exp_q.push_back('{kind: EV_MISO_FALL, cyc: c + 1});
            end
            sclk_strobe(1'b0);
        end
        completed = is_read ? (data_neg == 8) : (data_pos == 8);
    endtask

    task automatic test_reset();
        int r;
        reset = 1'b1;
        csConditioned = 1'b0;
        for (int i = 0; i < 3; i++) begin
            r = $urandom_range(0, 2);
            sclkPosEdge = (r == 1);
            sclkNegEdge = (r == 2);
            @(negedge clk);
            n_checks++;
            if ({srWe, addrWe, dmWe, misoBufe} !== 4'b0000)
                $display("FAIL reset_outputs: got %b, expected 0000", {srWe, addrWe, dmWe, misoBufe});
            else n_pass++;
            tick();
        end
        sclkPosEdge = 1'b0;
        sclkNegEdge = 1'b0;
        reset = 1'b0;
        csConditioned = 1'b1;
        n_checks++;
        if (dut.state_q !== IDLE) $display("FAIL reset_state: got %0d, expected %0d", dut.state_q, IDLE);
        else n_pass++;
        tick();
        n_checks++;
        if (dut.state_q !== IDLE) $display("FAIL idle_after_release: got %0d, expected %0d", dut.state_q, IDLE);
        else n_pass++;
    endtask

    task automatic test_read_frame(input int n_periods);
        bit done;
        run_frame(7'h15, 1'b1, 8'h00, n_periods, 0, done);
        repeat (4) tick();
        n_checks++;
        if (exp_q.size() !== 0) $display("FAIL read_pending: got %0d outstanding events, expected 0", exp_q.size());
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (dut.state_q !== DONE || {srWe, addrWe, dmWe, misoBufe} !== 4'b0000)
            $display("FAIL read_done: got state %0d outputs %b, expected state %0d outputs 0000",
                     dut.state_q, {srWe, addrWe, dmWe, misoBufe}, DONE);
        else n_pass++;
        tick();
        csConditioned = 1'b1;
        tick();
        n_checks++;
        if (dut.state_q !== IDLE) $display("FAIL read_release: got %0d, expected %0d", dut.state_q, IDLE);
        else n_pass++;
    endtask

    task automatic test_write_frame();
        bit done;
        run_frame(7'h2A, 1'b0, 8'hA5, 16, 0, done);
        repeat (4) tick();
        n_checks++;
        if (exp_q.size() !== 0) $display("FAIL write_pending: got %0d outstanding events, expected 0", exp_q.size());
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (dut.state_q !== DONE || {srWe, addrWe, dmWe, misoBufe} !== 4'b0000)
            $display("FAIL write_done: got state %0d outputs %b, expected state %0d outputs 0000",
                     dut.state_q, {srWe, addrWe, dmWe, misoBufe}, DONE);
        else n_pass++;
        tick();
        csConditioned = 1'b1;
        tick();
        n_checks++;
        if (dut.state_q !== IDLE) $display("FAIL write_release: got %0d, expected %0d", dut.state_q, IDLE);
        else n_pass++;
    endtask

    task automatic test_abort();
        bit done;
        run_frame(7'h2A, 1'b0, 8'hA5, 16, 12, done);
        tick();
        n_checks++;
        if (dut.state_q !== IDLE) $display("FAIL abort_state: got %0d, expected %0d", dut.state_q, IDLE);
        else n_pass++;
        repeat (8) tick();
        n_checks++;
        if (exp_q.size() !== 0) $display("FAIL abort_pending: got %0d outstanding events, expected 0", exp_q.size());
        else n_pass++;
        test_read_frame(16);
    endtask

    // Four extra sclk periods arrive while the read frame sits in DONE.
    task automatic test_done_extra_edges();
        test_read_frame(20);
    endtask

`ifdef SPI_FSM_TXN_COUNT_EN
    task automatic test_txn_count();
        bit done;
        int exp_txn = 0;
        csConditioned = 1'b1;
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        run_frame(7'h15, 1'b1, 8'h00, 16, 0, done);
        if (done) exp_txn++;
        repeat (4) tick();
        csConditioned = 1'b1;
        repeat (2) tick();
        run_frame(7'h2A, 1'b0, 8'h3C, 16, 0, done);
        if (done) exp_txn++;
        repeat (4) tick();
        csConditioned = 1'b1;
        repeat (2) tick();
        run_frame(7'h2A, 1'b0, 8'hA5, 16, 12, done);
        if (done) exp_txn++;
        repeat (4) tick();
        n_checks++;
        if (txnCount !== 8'(exp_txn)) $display("FAIL txn_count: got %0d, expected %0d", txnCount, exp_txn);
        else n_pass++;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++;
        if (txnCount !== 8'd0) $display("FAIL txn_reset: got %0d, expected 0", txnCount);
        else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_read_frame(16);
        test_write_frame();
        test_abort();
        test_done_extra_edges();
`ifdef SPI_FSM_TXN_COUNT_EN
        test_txn_count();
`endif
        repeat (2) tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/spi_fsm.md
Name: spi_fsm

Overview:
- Transaction controller for the SPI memory. Consumes the 8-bit shift register's contents and sclk edge strobes; drives the register's load control, address latch, data-memory write enable and MISO tri-state enable.
- Sits directly downstream of the shift register: it reads that register's parallelDataOut[0] and drives its parallelLoad.
- Frame, MSB first: 7 address bits, then the R/W bit (1 = read), then 8 data bits. On a read, the data bits go out on MISO; on a write, they come in on MOSI.

Parameters:
- width, 8, bits per SPI byte; sizes bitCount compare.
- settle, 2, clk cycles to wait after the last shift before the shift register's parallelDataOut is valid; this covers the register's 2-stage output lag.

Ports:
- clk, input, 1, FPGA clock.
- reset, input, 1, synchronous, active-high.
- csConditioned, input, 1, conditioned chip select, active low.
- sclkPosEdge, input, 1, one-clk strobe on the sclk rising edge.
- sclkNegEdge, input, 1, one-clk strobe on the sclk falling edge.
- rwBit, input, 1, parallelDataOut[0] of the shift register.
- srWe, output, 1, parallelLoad pulse to the shift register.
- addrWe, output, 1, address latch enable pulse.
- dmWe, output, 1, data memory write enable pulse.
- misoBufe, output, 1, MISO tri-state buffer enable.

Behaviour:
- Outputs are registered. srWe, addrWe and dmWe are single-clk pulses. misoBufe is a level.
- Reset state:
  - state = IDLE, bitCount = 0, settleCount = 0.
  - All outputs = 0.
  - Reset overrides every other input.
- Abort: csConditioned = 1 in any state other than IDLE → next cycle state = IDLE, counters = 0, outputs = 0. A write is never committed after an abort.

States and transitions:
- IDLE:
  - csConditioned = 0 → GET, with bitCount = 0.
- GET:
  - bitCount increments on each sclkPosEdge.
  - On the edge where bitCount reaches width → GOT, with settleCount = 0.
- GOT:
  - settleCount increments every clk.
  - When settleCount = settle - 1 → ADDR.
- ADDR:
  - addrWe = 1 for this one cycle.
  - rwBit sampled: 1 → READ_LOAD; 0 → WRITE_GET (bitCount = 0).
- READ_LOAD:
  - srWe = 1 for one cycle; the memory word is loaded into the shift register.
  - Then READ_SHIFT, with bitCount = 0.
- READ_SHIFT:
  - misoBufe = 1 throughout.
  - bitCount increments on each sclkNegEdge.
  - When bitCount reaches width → DONE.
- WRITE_GET:
  - bitCount increments on each sclkPosEdge.
  - When bitCount reaches width → WRITE_SETTLE, with settleCount = 0.
- WRITE_SETTLE:
  - Waits settle cycles, then → WRITE_COMMIT.
- WRITE_COMMIT:
  - dmWe = 1 for one cycle, then → DONE.
- DONE:
  - All outputs 0. Waits for csConditioned = 1 → IDLE.
  - Extra sclk edges in DONE are ignored.

Width and edge rules:
- bitCount is clog2(width)+1 bits wide. Compares are against width exactly; there is no wrap.
- sclkPosEdge and sclkNegEdge high in the same cycle is illegal upstream. Each state uses only its own edge type; the other is ignored.
- A sclk edge arriving in GOT, ADDR or READ_LOAD is ignored, not counted.

Optional Feature:
- Macro SPI_FSM_TXN_COUNT_EN.
- Defined:
  - Adds output txnCount [7:0].
  - txnCount increments by 1 on each entry to DONE and wraps 255→0.
  - Reset clears it to 0. Aborts do not increment it.
- Undefined:
  - The port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package spi_pkg:
  - state encoding constants: IDLE=0, GET=1, GOT=2, ADDR=3, READ_LOAD=4, READ_SHIFT=5, WRITE_GET=6, WRITE_SETTLE=7, WRITE_COMMIT=8, DONE=9.
  - SPI_WIDTH = 8.
  - SPI_SETTLE = 2.
- One natural sub-module: spi_edge_counter.
  - Parameterised edge-strobe counter with clear, enable and a done flag at width.
  - Instanced for the bit counter; the settle wait reuses it.

Test Plan:
1. Reset held for 3 clk with csConditioned = 0 and random strobes → all outputs 0; state IDLE after release.
2. Read frame (address 7'h15, rwBit = 1 after the 8th sclkPosEdge):
   - addrWe pulses once, settle+1 clk after the 8th edge;
   - srWe pulses on the next clk;
   - misoBufe stays 1 until the 8th sclkNegEdge, then drops; dmWe never asserts.
3. Write frame (address 7'h2A, rwBit = 0, data 8'hA5):
   - addrWe pulses once;
   - dmWe pulses exactly once, settle+1 clk after the 16th sclkPosEdge;
   - misoBufe stays 0 throughout.
4. Abort: csConditioned → 1 after 12 write-frame edges → IDLE next clk; dmWe never asserts. A following full read frame behaves as in scenario 2.
5. Extra edges in DONE: 4 additional sclkPosEdges → no output activity. Raising csConditioned returns the FSM to IDLE.
6. With SPI_FSM_TXN_COUNT_EN defined: two completed frames plus one aborted frame → txnCount = 2. Reset → txnCount = 0.
